// File: rtl/dmem_unit.sv
// dmem_unit: data-memory access unit between the core and a ready-strobed memory.
// Handles size/sign, lane steering, misalignment faults and a REQ-phase timeout.
module dmem_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        writesmem,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rd_q;
  logic        fault_q;

  logic        req;
  logic        f3_ok;
  logic        aligned;
  logic        legal;
  logic [3:0]  be_st;
  logic [31:0] wd_st;

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   ld_ext = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   ld_ext = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: ld_ext = w;
    endcase
  endfunction

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    req     = memread | writesmem;
    f3_ok   = !((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    aligned = 1'b0;
    be_st   = 4'b1111;
    wd_st   = writedata;
    case (funct3[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_st   = 4'b0001 << aluout[1:0];
        wd_st   = {4{writedata[7:0]}};
      end
      2'b01: begin
        aligned = !aluout[0];
        be_st   = 4'b0011 << {aluout[1], 1'b0};
        wd_st   = {2{writedata[15:0]}};
      end
      2'b10: aligned = (aluout[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal = f3_ok & aligned;
  end

  // Next-state logic and the combinational stall/mem_req outputs.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = legal ? REQ : DONE;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready || (cnt_q == CNT_LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the access, counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            rd_q <= '0;
            if (legal) begin
              addr_q  <= {aluout[31:2], 2'b00};
              we_q    <= writesmem;
              be_q    <= writesmem ? be_st : 4'b1111;
              wdata_q <= writesmem ? wd_st : 32'd0;
              f3_q    <= funct3;
              off_q   <= aluout[1:0];
              cnt_q   <= '0;
              fault_q <= 1'b0;
            end else begin
              fault_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            rd_q    <= we_q ? 32'd0 : ld_ext(mem_rdata, f3_q, off_q);
            fault_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            rd_q    <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          rd_q    <= '0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign readdata  = rd_q;
  assign fault     = fault_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed bench for dmem_unit with TIMEOUT=4.
// Inputs change and outputs are sampled at the falling edge.
module tb_dmem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        writesmem;
  logic [2:0]  funct3;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  dmem_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .writesmem (writesmem),
    .funct3    (funct3),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    memread   = rd;
    writesmem = wr;
    funct3    = f3;
    aluout    = a;
    writedata = wd;
  endtask

  // Legal access with mem_ready in the first REQ cycle; ends in DONE.
  task automatic acc(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rdat,
                     input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wd, input logic [31:0] e_rd);
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    #1;
    chk({tag, ".stall_req"}, 32'(stall), 32'd1);
    chk({tag, ".mreq_idle"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = rdat;
    #1;
    chk({tag, ".stall_req2"}, 32'(stall), 32'd1);
    chk({tag, ".mreq"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, mem_addr, e_addr);
    chk({tag, ".be"}, 32'(mem_be), 32'(e_be));
    chk({tag, ".we"}, 32'(mem_we), 32'(wr));
    if (wr) chk({tag, ".wdata"}, mem_wdata, e_wd);
    @(negedge clk);
    mem_ready = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".mreq_done"}, 32'(mem_req), 32'd0);
    chk({tag, ".rdata"}, readdata, e_rd);
  endtask

  // Illegal request: no memory access, one-cycle fault in DONE.
  task automatic bad(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    drive(rd, wr, f3, a, 32'hFFFF_FFFF);
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'd1);
    chk({tag, ".mreq0"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    chk({tag, ".fault"}, 32'(fault), 32'd1);
    chk({tag, ".mreq1"}, 32'(mem_req), 32'd0);
    chk({tag, ".rdata"}, readdata, 32'd0);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, ".fault_off"}, 32'(fault), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.mreq", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.rdata", readdata, 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Idle with stray mem_ready: nothing happens.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_5555;
    #1;
    chk("idle.stall", 32'(stall), 32'd0);
    chk("idle.mreq", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("idle.fault", 32'(fault), 32'd0);
    chk("idle.rdata", readdata, 32'd0);

    acc("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF,
        32'h100, 4'b1111, 0, 32'hDEADBEEF);
    acc("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80112233,
        32'h100, 4'b1111, 0, 32'hFFFFFF80);
    acc("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80112233,
        32'h100, 4'b1111, 0, 32'h00000080);
    acc("lb1", 1, 0, 3'b000, 32'h101, 0, 32'h80112233,
        32'h100, 4'b1111, 0, 32'h00000022);
    acc("lh", 1, 0, 3'b001, 32'h102, 0, 32'h80112233,
        32'h100, 4'b1111, 0, 32'hFFFF8011);
    acc("lhu", 1, 0, 3'b101, 32'h100, 0, 32'h80112233,
        32'h100, 4'b1111, 0, 32'h00002233);
    acc("sb", 0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h77777777,
        32'h200, 4'b0010, 32'hABABABAB, 32'd0);
    acc("sh", 0, 1, 3'b001, 32'h202, 32'h00001234, 32'h77777777,
        32'h200, 4'b1100, 32'h12341234, 32'd0);
    acc("sw", 0, 1, 3'b010, 32'h204, 32'h89ABCDEF, 32'h77777777,
        32'h204, 4'b1111, 32'h89ABCDEF, 32'd0);
    acc("ldst", 1, 1, 3'b010, 32'h500, 32'hCAFEF00D, 32'h12345678,
        32'h500, 4'b1111, 32'hCAFEF00D, 32'd0);

    bad("lw_mis", 1, 0, 3'b010, 32'h102);
    bad("f3_011", 1, 0, 3'b011, 32'h100);
    bad("sh_mis", 0, 1, 3'b001, 32'h201);
    bad("f3_110", 1, 0, 3'b110, 32'h100);

    // Timeout: four REQ cycles without mem_ready, then fault.
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h300, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to.mreq%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("to.stall%0d", i), 32'(stall), 32'd1);
    end
    @(negedge clk);
    drive(0, 0, 3'b000, 0, 0);
    #1;
    chk("to.fault", 32'(fault), 32'd1);
    chk("to.stall", 32'(stall), 32'd0);
    chk("to.mreq", 32'(mem_req), 32'd0);
    chk("to.rdata", readdata, 32'd0);
    @(negedge clk);
    #1;
    chk("to.fault_off", 32'(fault), 32'd0);

    // mem_ready on the last allowed REQ cycle counts as success.
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h304, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h11223344;
      end
      #1;
      chk($sformatf("tl.mreq%0d", i), 32'(mem_req), 32'd1);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    drive(0, 0, 3'b000, 0, 0);
    #1;
    chk("tl.fault", 32'(fault), 32'd0);
    chk("tl.rdata", readdata, 32'h11223344);
    chk("tl.stall", 32'(stall), 32'd0);

    // Reset in the second REQ cycle, late mem_ready afterwards.
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h400, 0);
    @(negedge clk);
    #1;
    chk("rr.mreq1", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rr.mreq2", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h99999999;
    drive(0, 0, 3'b000, 0, 0);
    #1;
    chk("rr.mreq_after", 32'(mem_req), 32'd0);
    chk("rr.stall_after", 32'(stall), 32'd0);
    chk("rr.addr", mem_addr, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("rr.fault", 32'(fault), 32'd0);
    chk("rr.rdata", readdata, 32'd0);
    chk("rr.mreq_late", 32'(mem_req), 32'd0);
    chk("rr.stall_late", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles in REQ waiting for mem_ready before abort (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 memread  in  1  load request from core for current instruction.
REQ-005 writesmem  in  1  store request from core for current instruction.
REQ-006 funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 aluout  in  32  byte address from core ALU.
REQ-008 writedata  in  32  store data from core (low-order bytes significant).
REQ-009 readdata  out  32  aligned, extended load result; valid in DONE.
REQ-010 stall  out  1  core must hold current instruction while high.
REQ-011 fault  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout.
REQ-012 mem_req  out  1  memory request, held until mem_ready.
REQ-013 mem_we  out  1  1 = write, 0 = read.
REQ-014 mem_addr  out  32  word address, {aluout[31:2],2'b00}.
REQ-015 mem_be  out  4  byte enables for writes; 4'b1111 for reads.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ready  in  1  memory completion strobe, one cycle.
REQ-018 mem_rdata  in  32  read word, valid when mem_ready=1.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DONE; request = memread|writesmem.
REQ-020 IDLE, no request: stay IDLE, stall=0, mem_req=0.
REQ-021 IDLE, legal aligned request: stall=1 combinationally same cycle; register addr/we/be/wdata/funct3/offset; next state REQ with mem_req=1.
REQ-022 IDLE, illegal request (misaligned or funct3 011/110/111): no memory access; next state DONE with fault=1, readdata=0; stall=1 in request cycle.
REQ-023 Alignment: halfword needs aluout[0]=0; word needs aluout[1:0]=00; byte always aligned.
REQ-024 memread and writesmem both high: store performed, load ignored.
REQ-025 REQ: stall=1, mem_req=1 and all mem_* stable; on mem_ready=1 capture mem_rdata, drop mem_req next cycle, go DONE.
REQ-026 REQ timeout: 8-bit counter cleared on REQ entry, increments each REQ cycle without mem_ready; at TIMEOUT-1 without mem_ready go DONE, fault=1, readdata=0, mem_req low next cycle.
REQ-027 mem_ready on the timeout cycle SHALL count as success (no fault).
REQ-028 DONE: stall=0, readdata/fault valid exactly this cycle, request inputs ignored; next state IDLE unconditionally.
REQ-029 Minimum access latency: request cycle + REQ cycles + DONE = 3 cycles with mem_ready in first REQ cycle.
REQ-030 Store lanes: SB be=4'b0001<<aluout[1:0], wdata={4{writedata[7:0]}}; SH be=4'b0011<<{aluout[1],1'b0}, wdata={2{writedata[15:0]}}; SW be=4'b1111, wdata=writedata.
REQ-031 Load extract: byte lane offset[1:0], halfword lane offset[1]; sign-extend when funct3[2]=0, zero-extend when 1.
REQ-032 Store completion SHALL set readdata=0.
REQ-033 mem_ready outside REQ SHALL be ignored.
REQ-034 fault SHALL be high only in DONE, never more than one cycle per access.

Reset
REQ-035 On reset=1 at a clock edge: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, readdata=0, fault=0, counter=0.
REQ-036 Reset mid-REQ SHALL abandon the access; late mem_ready SHALL be ignored; stall SHALL be 0 in the cycle after reset unless a new request is present.
REQ-037 Reset has priority over mem_ready and new requests on the same edge.

Verification
REQ-038 LW aluout=0x100, mem_ready on 1st REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, stall 1,1,0, readdata=0xDEADBEEF in DONE.
REQ-039 LB aluout=0x103, mem_rdata=0x80112233 -> readdata=0xFFFFFF80; same with LBU -> 0x00000080; LH 0x102 -> 0xFFFF8011.
REQ-040 SB aluout=0x201, writedata=0x000000AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x200; SH 0x202 data 0x1234 -> be=1100, wdata=0x12341234.
REQ-041 LW aluout=0x102 -> no mem_req, fault=1 one cycle, readdata=0; funct3=011 -> same.
REQ-042 TIMEOUT=4, mem_ready never asserted -> mem_req high 4 cycles, then fault=1 in DONE, stall=0; mem_ready on 4th cycle -> no fault.
REQ-043 reset pulsed in 2nd REQ cycle, mem_ready next cycle -> mem_req=0 after reset, no DONE, fault=0, readdata=0.
